// File: rtl/rca_seq_addsub.sv
// Chunk-serial ripple-carry adder/subtractor.
// A WIDTH-bit add or subtract is performed CHUNK bits per clock through a
// single CHUNK-bit ripple slice and one registered carry, so an operation
// occupies WIDTH/CHUNK RUN cycles followed by a one-cycle done pulse.
// Subtraction is a + ~b + 1: the inverted operand is stored at accept time
// and the carry register is preset to 1, so the RUN datapath is identical
// for both modes.
module rca_seq_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  // Number of slices per operation and the width of the slice counter
  // (at least one bit, even when a single slice covers the whole word).
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_cOut;
  logic             r_ovf;

  int               w_base;
  logic [CHUNK-1:0] w_aChunk;
  logic [CHUNK-1:0] w_bChunk;
  logic [CHUNK:0]   w_chunkResult;
  logic             w_carryIntoMsb;

  // Select the current slice of both operands and ripple it with the stored carry.
  always_comb begin
    w_base         = int'(r_cnt) * CHUNK;
    w_aChunk       = CHUNK'(r_a >> w_base);
    w_bChunk       = CHUNK'(r_b >> w_base);
    w_chunkResult  = {1'b0, w_aChunk} + {1'b0, w_bChunk} + {{CHUNK{1'b0}}, r_carry};
    w_carryIntoMsb = w_aChunk[CHUNK-1] ^ w_bChunk[CHUNK-1] ^ w_chunkResult[CHUNK-1];
  end

  // Control FSM and datapath registers; results hold until the next accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cOut  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : c_in;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_sum[w_base +: CHUNK] <= w_chunkResult[CHUNK-1:0];
          r_carry                <= w_chunkResult[CHUNK];
          if (r_cnt == LAST_CHUNK) begin
            r_cOut  <= w_chunkResult[CHUNK];
            r_ovf   <= w_carryIntoMsb ^ w_chunkResult[CHUNK];
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign sum   = r_sum;
  assign c_out = r_cOut;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_rca_seq_addsub.sv
// Self-checking bench for rca_seq_addsub: directed table and corner-case
// sequences on a 16/4 instance, random traffic on 32/8 and 8/8 instances.
module tb_rca_seq_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  // Edge counter used to timestamp accepts and dones.
  always @(posedge clk) cyc <= cyc + 1;

  logic        start0, sub0, cin0, busy0, done0, cout0, ovf0;
  logic [15:0] a0, b0, sum0;
  logic        start1, sub1, cin1, busy1, done1, cout1, ovf1;
  logic [31:0] a1, b1, sum1;
  logic        start2, sub2, cin2, busy2, done2, cout2, ovf2;
  logic [7:0]  a2, b2, sum2;

  rca_seq_addsub #(.WIDTH(16), .CHUNK(4)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .sub(sub0), .a(a0), .b(b0), .c_in(cin0),
    .busy(busy0), .done(done0), .sum(sum0), .c_out(cout0), .ovf(ovf0));

  rca_seq_addsub #(.WIDTH(32), .CHUNK(8)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1), .c_in(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .c_out(cout1), .ovf(ovf1));

  rca_seq_addsub #(.WIDTH(8), .CHUNK(8)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .sub(sub2), .a(a2), .b(b2), .c_in(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .c_out(cout2), .ovf(ovf2));

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic reportFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: got no matching event, required one", name);
  endtask

  // Reference: full-width add of a and (possibly inverted) b, overflow from operand/result signs.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, input logic cin);
    exp_t        r;
    logic [31:0] mask, aa, bb;
    logic [32:0] full;
    mask   = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    aa     = a & mask;
    bb     = (sub ? ~b : b) & mask;
    full   = {1'b0, aa} + {1'b0, bb} + {32'd0, (sub ? 1'b1 : cin)};
    r.sum  = full[31:0] & mask;
    r.cout = full[w];
    r.ovf  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
    r.acc  = 0;
    return r;
  endfunction

  function automatic logic doneOf(input int d);
    case (d)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  // Called at a negedge: drives one start pulse, queues the expectation,
  // then scrambles the operand inputs to show they are no longer observed.
  task automatic applyStimulus(input int d, input logic [31:0] a, input logic [31:0] b,
                               input logic sub, input logic cin, input exp_t e);
    exp_t r;
    r     = e;
    r.acc = cyc + 1;
    case (d)
      0: begin a0 = a[15:0]; b0 = b[15:0]; sub0 = sub; cin0 = cin; start0 = 1'b1; q0.push_back(r); end
      1: begin a1 = a;       b1 = b;       sub1 = sub; cin1 = cin; start1 = 1'b1; q1.push_back(r); end
      default: begin a2 = a[7:0]; b2 = b[7:0]; sub2 = sub; cin2 = cin; start2 = 1'b1; q2.push_back(r); end
    endcase
    @(negedge clk);
    case (d)
      0: begin start0 = 1'b0; a0 = 16'($urandom); b0 = 16'($urandom); sub0 = 1'($urandom); cin0 = 1'($urandom); end
      1: begin start1 = 1'b0; a1 = $urandom; b1 = $urandom; sub1 = 1'($urandom); cin1 = 1'($urandom); end
      default: begin start2 = 1'b0; a2 = 8'($urandom); b2 = 8'($urandom); sub2 = 1'($urandom); cin2 = 1'($urandom); end
    endcase
  endtask

  // Waits (bounded) until the selected instance shows done at a negedge.
  task automatic waitDone(input int d, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!doneOf(d) && n < 60);
    if (!doneOf(d)) reportFail({tag, "_timeout"});
  endtask

  // Pops the oldest expectation for an instance and compares the completed result.
  task automatic checkDone(input int d, input logic [31:0] s, input logic co,
                           input logic ov, input int lat);
    exp_t  e;
    string p;
    int    sz;
    p  = $sformatf("d%0d", d);
    sz = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
    if (sz == 0) begin
      reportFail({p, "_spurious_done"});
    end else begin
      case (d)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      checkOutput({p, "_sum"}, s, e.sum);
      checkOutput({p, "_cout"}, 32'(co), 32'(e.cout));
      checkOutput({p, "_ovf"}, 32'(ov), 32'(e.ovf));
      checkOutput({p, "_latency"}, 32'(cyc - e.acc), 32'(lat));
    end
  endtask

  // Output monitors: every done pulse must match the oldest outstanding operation.
  always @(negedge clk) if (done0) checkDone(0, 32'(sum0), cout0, ovf0, 4);
  always @(negedge clk) if (done1) checkDone(1, sum1, cout1, ovf1, 4);
  always @(negedge clk) if (done2) checkDone(2, 32'(sum2), cout2, ovf2, 1);

  function automatic exp_t vecExp(input vec_t v);
    exp_t r;
    r.sum  = 32'(v.sum);
    r.cout = v.cout;
    r.ovf  = v.ovf;
    r.acc  = 0;
    return r;
  endfunction

  function automatic exp_t constExp(input logic [15:0] s, input logic co, input logic ov);
    exp_t r;
    r.sum  = 32'(s);
    r.cout = co;
    r.ovf  = ov;
    r.acc  = 0;
    return r;
  endfunction

  initial begin
    int          busyCnt;
    logic [31:0] ra, rb;
    logic        rs, rc;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0};
    vecs[6] = '{16'h0007, 16'h0007, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[8] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[9] = '{16'h0000, 16'h8000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};

    rst = 1'b1;
    start0 = 1'b0; sub0 = 1'b0; cin0 = 1'b0; a0 = '0; b0 = '0;
    start1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
    start2 = 1'b0; sub2 = 1'b0; cin2 = 1'b0; a2 = '0; b2 = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(busy0), 32'd0);
    checkOutput("rst_done", 32'(done0), 32'd0);
    checkOutput("rst_sum", 32'(sum0), 32'd0);
    checkOutput("rst_cout", 32'(cout0), 32'd0);
    checkOutput("rst_ovf", 32'(ovf0), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Busy stays high for exactly the four RUN cycles of a 16/4 operation.
    applyStimulus(0, 32'(vecs[0].a), 32'(vecs[0].b), vecs[0].sub, vecs[0].cin, vecExp(vecs[0]));
    busyCnt = int'(busy0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      busyCnt += int'(busy0);
    end
    checkOutput("busy_cycles", 32'(busyCnt), 32'd4);

    // Directed table, issued back to back from the DONE cycle where possible.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 32'(vecs[i].a), 32'(vecs[i].b), vecs[i].sub, vecs[i].cin, vecExp(vecs[i]));
      waitDone(0, $sformatf("vec%0d", i));
    end

    // A start pulse during RUN must be ignored.
    applyStimulus(0, 32'h0001, 32'h0001, 1'b0, 1'b0, constExp(16'h0002, 1'b0, 1'b0));
    a0 = 16'hAAAA;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    waitDone(0, "ignore_start");

    // Start raised in the DONE cycle is accepted immediately.
    applyStimulus(0, 32'h0010, 32'h0020, 1'b0, 1'b0, constExp(16'h0030, 1'b0, 1'b0));
    waitDone(0, "back_to_back");

    // Reset in the second RUN cycle discards the operation.
    repeat (2) @(negedge clk);
    applyStimulus(0, 32'h00F0, 32'h0F00, 1'b0, 1'b0, constExp(16'h0FF0, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_busy", 32'(busy0), 32'd0);
    checkOutput("midrst_done", 32'(done0), 32'd0);
    checkOutput("midrst_sum", 32'(sum0), 32'd0);
    checkOutput("midrst_cout", 32'(cout0), 32'd0);
    checkOutput("midrst_ovf", 32'(ovf0), 32'd0);
    rst = 1'b0;
    q0.delete();
    repeat (8) @(negedge clk);
    applyStimulus(0, 32'h0F0F, 32'h00F1, 1'b0, 1'b0, constExp(16'h1000, 1'b0, 1'b0));
    waitDone(0, "after_rst");

    // Random traffic on the wide and single-slice instances in parallel.
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          ra = $urandom;
          rb = $urandom;
          rs = 1'($urandom);
          rc = 1'($urandom);
          applyStimulus(1, ra, rb, rs, rc, model(32, ra, rb, rs, rc));
          waitDone(1, "rnd32");
        end
      end
      begin
        logic [31:0] xa, xb;
        logic        xs, xc;
        for (int j = 0; j < 1000; j++) begin
          xa = $urandom;
          xb = $urandom;
          xs = 1'($urandom);
          xc = 1'($urandom);
          applyStimulus(2, xa, xb, xs, xc, model(8, xa, xb, xs, xc));
          waitDone(2, "rnd8");
        end
      end
    join

    repeat (6) @(negedge clk);
    checkOutput("q0_drained", 32'(q0.size()), 32'd0);
    checkOutput("q1_drained", 32'(q1.size()), 32'd0);
    checkOutput("q2_drained", 32'(q2.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
